// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - round sequencer and two-port arbiter for an iterative AES datapath
// Define AES_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module aes_round_sched #(
  parameter int NK    = 4,
  parameter int NR    = NK + 6,
  parameter int RK_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [255:0]     req_pt,
  input  logic             key_ready,
  output logic [RK_AW-1:0] rk_addr,
  output logic [127:0]     core_din,
  output logic             core_load,
  output logic             core_step,
  output logic             core_final,
  input  logic [127:0]     core_dout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [127:0]     rsp_ct,
  output logic             rsp_id,
  output logic             err_abort
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [RK_AW-1:0] LAST_RND = RK_AW'(NR);

  state_t           state_q, state_d;
  logic [RK_AW-1:0] rnd_q, rnd_d;
  logic             id_q, id_d;
  logic             grant_vld;
  logic             grant_id;

  assign grant_vld = rst_n && key_ready && (req_valid != 2'b00) && (state_q == IDLE);

`ifdef AES_SCHED_RR_EN
  logic last_q, last_d;

  always_comb begin
    grant_id = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    last_d   = last_q;
    if (grant_vld) last_d = grant_id;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign grant_id = ~req_valid[0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = ROUND;
          rnd_d   = RK_AW'(1);
          id_d    = grant_id;
        end
      end
      ROUND: begin
        // Losing the key schedule mid-block drops the block without a response.
        if (!key_ready) begin
          state_d = IDLE;
          rnd_d   = '0;
        end else if (rnd_q == LAST_RND) begin
          state_d = DONE;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + RK_AW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 2'b00;
    rk_addr    = '0;
    core_din   = '0;
    core_load  = 1'b0;
    core_step  = 1'b0;
    core_final = 1'b0;
    rsp_valid  = 1'b0;
    rsp_ct     = '0;
    rsp_id     = 1'b0;
    err_abort  = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            req_ready[grant_id] = 1'b1;
            core_load           = 1'b1;
            core_din            = grant_id ? req_pt[255:128] : req_pt[127:0];
          end
        end
        ROUND: begin
          if (key_ready) begin
            rk_addr = rnd_q;
            if (rnd_q == LAST_RND) core_final = 1'b1;
            else                   core_step  = 1'b1;
          end else begin
            err_abort = 1'b1;
          end
        end
        DONE: begin
          // The datapath holds its state while no strobe is asserted.
          rsp_valid = 1'b1;
          rsp_ct    = core_dout;
          rsp_id    = id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// tb/tb_aes_round_sched.sv - directed bench for aes_round_sched with a behavioural AES datapath and key store
// Expected grant order follows AES_SCHED_RR_EN.
module tb_aes_round_sched;

  localparam int NR4 = 10;
  localparam int NR8 = 14;
  localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT_C   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_A8  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst_n, key_ready, rsp_ready;
  logic [255:0] req_pt;
  logic [1:0]   req_valid4, req_ready4, req_valid8, req_ready8;
  logic [3:0]   rk_addr4, rk_addr8;
  logic [127:0] core_din4, core_din8, rsp_ct4, rsp_ct8;
  logic [127:0] st4 = '0, st8 = '0;
  logic         core_load4, core_step4, core_final4, rsp_valid4, rsp_id4, err_abort4;
  logic         core_load8, core_step8, core_final8, rsp_valid8, rsp_id8, err_abort8;

  logic [7:0]   sb  [0:255];
  logic [31:0]  w   [0:59];
  logic [127:0] rk4 [0:15];
  logic [127:0] rk8 [0:15];
  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  aes_round_sched u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4), .req_pt(req_pt),
    .key_ready(key_ready), .rk_addr(rk_addr4), .core_din(core_din4), .core_load(core_load4),
    .core_step(core_step4), .core_final(core_final4), .core_dout(st4), .rsp_valid(rsp_valid4),
    .rsp_ready(rsp_ready), .rsp_ct(rsp_ct4), .rsp_id(rsp_id4), .err_abort(err_abort4)
  );

  aes_round_sched #(.NK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid8), .req_ready(req_ready8), .req_pt(req_pt),
    .key_ready(key_ready), .rk_addr(rk_addr8), .core_din(core_din8), .core_load(core_load8),
    .core_step(core_step8), .core_final(core_final8), .core_dout(st8), .rsp_valid(rsp_valid8),
    .rsp_ready(rsp_ready), .rsp_ct(rsp_ct8), .rsp_id(rsp_id8), .err_abort(err_abort8)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sb[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8]; a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] enc4(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk4[0];
    for (int r = 1; r < NR4; r++) s = mix(sub_shift(s)) ^ rk4[r];
    return sub_shift(s) ^ rk4[NR4];
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
  endtask

  // Datapath models: state register updated only on a strobe, keyed by rk_addr.
  always @(posedge clk) begin
    if (core_load4)       st4 <= core_din4 ^ rk4[rk_addr4];
    else if (core_step4)  st4 <= mix(sub_shift(st4)) ^ rk4[rk_addr4];
    else if (core_final4) st4 <= sub_shift(st4) ^ rk4[rk_addr4];
    if (core_load8)       st8 <= core_din8 ^ rk8[rk_addr8];
    else if (core_step8)  st8 <= mix(sub_shift(st8)) ^ rk8[rk_addr8];
    else if (core_final8) st8 <= sub_shift(st8) ^ rk8[rk_addr8];
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    req_pt = {PT_B, PT_A}; req_valid4 = 2'b01; #1;
    ntests++; if ({req_ready4, rk_addr4, core_din4, core_load4, core_step4, core_final4, rsp_valid4, rsp_ct4, rsp_id4, err_abort4} !== '0) begin
      nfail++; $display("FAIL reset_outputs4: req_ready=%b core_load=%b rsp_valid=%b expected all zero", req_ready4, core_load4, rsp_valid4); end
    ntests++; if ({req_ready8, rk_addr8, core_din8, core_load8, core_step8, core_final8, rsp_valid8, rsp_ct8, rsp_id8, err_abort8} !== '0) begin
      nfail++; $display("FAIL reset_outputs8: req_ready=%b rsp_valid=%b expected all zero", req_ready8, rsp_valid8); end
    @(negedge clk); rst_n = 1'b1; req_valid4 = 2'b00; #1;
    ntests++; if ({req_ready4, rk_addr4, core_din4, core_load4, core_step4, core_final4, rsp_valid4, rsp_ct4, rsp_id4, err_abort4} !== '0) begin
      nfail++; $display("FAIL idle_outputs4: req_ready=%b rsp_valid=%b expected all zero", req_ready4, rsp_valid4); end
  endtask

  task automatic test_single_block();
    @(negedge clk); req_pt = {PT_B, PT_A}; req_valid4 = 2'b01; #1;
    ntests++; if ({req_ready4, core_load4, rk_addr4, core_din4} !== {2'b01, 1'b1, 4'd0, PT_A}) begin
      nfail++; $display("FAIL single_accept: req_ready=%b load=%b rk_addr=%0d din=%h expected 01 1 0 %h", req_ready4, core_load4, rk_addr4, core_din4, PT_A); end
    for (int k = 1; k <= NR4; k++) begin
      @(negedge clk); req_valid4 = 2'b00; #1;
      ntests++; if ({core_load4, core_step4, core_final4, rk_addr4, rsp_valid4} !== {1'b0, k < NR4, k == NR4, 4'(k), 1'b0}) begin
        nfail++; $display("FAIL single_round%0d: load/step/final=%b%b%b rk_addr=%0d rsp_valid=%b", k, core_load4, core_step4, core_final4, rk_addr4, rsp_valid4); end
    end
    @(negedge clk); #1;
    ntests++; if ({rsp_valid4, rsp_id4, rsp_ct4} !== {1'b1, 1'b0, CT_A4}) begin
      nfail++; $display("FAIL single_response: valid=%b id=%b ct=%h expected 1 0 %h", rsp_valid4, rsp_id4, rsp_ct4, CT_A4); end
    @(negedge clk); rsp_ready = 1'b1; #1;
    ntests++; if ({rsp_valid4, req_ready4} !== 3'b100) begin
      nfail++; $display("FAIL single_hold: rsp_valid=%b req_ready=%b expected 1 00", rsp_valid4, req_ready4); end
    @(negedge clk); rsp_ready = 1'b0; #1;
    ntests++; if (rsp_valid4 !== 1'b0) begin
      nfail++; $display("FAIL single_release: rsp_valid=%b expected 0", rsp_valid4); end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_c, exp_b;
    exp_c = enc4(PT_C); exp_b = enc4(PT_B);
    @(negedge clk); req_pt = {PT_B, PT_C}; req_valid4 = 2'b01; #1;
    ntests++; if (req_ready4 !== 2'b01) begin
      nfail++; $display("FAIL bp_accept0: req_ready=%b expected 01", req_ready4); end
    for (int k = 1; k <= NR4; k++) begin
      @(negedge clk); req_valid4 = 2'b10; #1;
      ntests++; if (req_ready4 !== 2'b00) begin
        nfail++; $display("FAIL bp_round_ready%0d: req_ready=%b expected 00", k, req_ready4); end
    end
    for (int d = 0; d < 5; d++) begin
      @(negedge clk); #1;
      ntests++; if ({rsp_valid4, rsp_id4, rsp_ct4, req_ready4} !== {1'b1, 1'b0, exp_c, 2'b00}) begin
        nfail++; $display("FAIL bp_stall%0d: valid=%b id=%b ct=%h req_ready=%b expected 1 0 %h 00", d, rsp_valid4, rsp_id4, rsp_ct4, req_ready4, exp_c); end
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    ntests++; if ({rsp_valid4, req_ready4} !== 3'b100) begin
      nfail++; $display("FAIL bp_release: rsp_valid=%b req_ready=%b expected 1 00", rsp_valid4, req_ready4); end
    @(negedge clk); rsp_ready = 1'b0; #1;
    ntests++; if ({req_ready4, core_load4, core_din4} !== {2'b10, 1'b1, PT_B}) begin
      nfail++; $display("FAIL bp_next_accept: req_ready=%b load=%b din=%h expected 10 1 %h", req_ready4, core_load4, core_din4, PT_B); end
    for (int k = 1; k <= NR4 + 1; k++) begin
      @(negedge clk); req_valid4 = 2'b00; #1;
    end
    ntests++; if ({rsp_valid4, rsp_id4, rsp_ct4} !== {1'b1, 1'b1, exp_b}) begin
      nfail++; $display("FAIL bp_resp1: valid=%b id=%b ct=%h expected 1 1 %h", rsp_valid4, rsp_id4, rsp_ct4, exp_b); end
    @(negedge clk); rsp_ready = 1'b1; #1;
    @(negedge clk); rsp_ready = 1'b0; #1;
  endtask

  task automatic test_abort();
    logic [127:0] exp_c;
    exp_c = enc4(PT_C);
    @(negedge clk); key_ready = 1'b0; req_pt = {PT_B, PT_A}; req_valid4 = 2'b01; #1;
    ntests++; if ({req_ready4, core_load4} !== 3'b000) begin
      nfail++; $display("FAIL nokey_wait0: req_ready=%b load=%b expected 00 0", req_ready4, core_load4); end
    @(negedge clk); #1;
    ntests++; if ({req_ready4, core_load4} !== 3'b000) begin
      nfail++; $display("FAIL nokey_wait1: req_ready=%b load=%b expected 00 0", req_ready4, core_load4); end
    @(negedge clk); key_ready = 1'b1; #1;
    ntests++; if (req_ready4 !== 2'b01) begin
      nfail++; $display("FAIL abort_accept: req_ready=%b expected 01", req_ready4); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); req_valid4 = 2'b00; #1;
    end
    @(negedge clk); key_ready = 1'b0; #1;
    ntests++; if ({err_abort4, core_load4, core_step4, core_final4, rk_addr4} !== {1'b1, 3'b000, 4'd0}) begin
      nfail++; $display("FAIL abort_pulse: err_abort=%b strobes=%b%b%b rk_addr=%0d expected 1 000 0", err_abort4, core_load4, core_step4, core_final4, rk_addr4); end
    @(negedge clk); key_ready = 1'b1; req_pt = {PT_B, PT_C}; req_valid4 = 2'b01; #1;
    ntests++; if ({err_abort4, rsp_valid4, req_ready4} !== 4'b0001) begin
      nfail++; $display("FAIL abort_idle: err_abort=%b rsp_valid=%b req_ready=%b expected 0 0 01", err_abort4, rsp_valid4, req_ready4); end
    for (int k = 1; k <= NR4; k++) begin
      @(negedge clk); req_valid4 = 2'b00; #1;
      ntests++; if ({rsp_valid4, err_abort4} !== 2'b00) begin
        nfail++; $display("FAIL abort_rerun%0d: rsp_valid=%b err_abort=%b expected 0 0", k, rsp_valid4, err_abort4); end
    end
    @(negedge clk); #1;
    ntests++; if ({rsp_valid4, rsp_ct4} !== {1'b1, exp_c}) begin
      nfail++; $display("FAIL abort_next_ct: valid=%b ct=%h expected 1 %h", rsp_valid4, rsp_ct4, exp_c); end
    @(negedge clk); rsp_ready = 1'b1; #1;
    @(negedge clk); rsp_ready = 1'b0; #1;
  endtask

  task automatic test_arbitration();
    logic [3:0]   exp_ids;
    logic [127:0] exp_b;
    logic         gid;
    bit           ok;
    int           at, prev;
`ifdef AES_SCHED_RR_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    exp_b = enc4(PT_B);
    at = 0; prev = 0; gid = 1'b0;
    @(negedge clk); rst_n = 1'b0; req_valid4 = 2'b00; #1;
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1; req_pt = {PT_B, PT_A}; req_valid4 = 2'b11; #1;
    for (int b = 0; b < 4; b++) begin
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
        if (req_ready4 != 2'b00) begin ok = 1'b1; at = cyc; gid = req_ready4[1]; end
        else begin @(negedge clk); #1; end
      end
      ntests++; if (!ok) begin
        nfail++; $display("FAIL arb_grant%0d: no grant within 40 cycles, expected one", b); end
      ntests++; if (gid !== exp_ids[b]) begin
        nfail++; $display("FAIL arb_id%0d: granted %b expected %b", b, gid, exp_ids[b]); end
      if (b > 0) begin
        ntests++; if (at - prev != NR4 + 2) begin
          nfail++; $display("FAIL arb_spacing%0d: %0d cycles expected %0d", b, at - prev, NR4 + 2); end
      end
      prev = at;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
        @(negedge clk); #1;
        if (rsp_valid4) ok = 1'b1;
      end
      ntests++; if (!ok || {rsp_id4, rsp_ct4} !== {gid, gid ? exp_b : CT_A4}) begin
        nfail++; $display("FAIL arb_resp%0d: seen=%b id=%b ct=%h expected id %b", b, ok, rsp_id4, rsp_ct4, gid); end
    end
    @(negedge clk); req_valid4 = 2'b00; rsp_ready = 1'b0; #1;
  endtask

  task automatic test_reset_mid_round();
    @(negedge clk); req_pt = {PT_B, PT_A}; req_valid8 = 2'b01; #1;
    ntests++; if ({req_ready8, core_load8} !== 3'b011) begin
      nfail++; $display("FAIL r8_accept: req_ready=%b load=%b expected 01 1", req_ready8, core_load8); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); req_valid8 = 2'b00; #1;
    end
    ntests++; if ({core_step8, rk_addr8} !== {1'b1, 4'd3}) begin
      nfail++; $display("FAIL r8_round3: step=%b rk_addr=%0d expected 1 3", core_step8, rk_addr8); end
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    ntests++; if ({req_ready8, rk_addr8, core_din8, core_load8, core_step8, core_final8, rsp_valid8, rsp_ct8, rsp_id8, err_abort8} !== '0) begin
      nfail++; $display("FAIL r8_after_reset: step=%b rk_addr=%0d rsp_valid=%b err_abort=%b expected all zero", core_step8, rk_addr8, rsp_valid8, err_abort8); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      ntests++; if ({rsp_valid8, err_abort8} !== 2'b00) begin
        nfail++; $display("FAIL r8_quiet%0d: rsp_valid=%b err_abort=%b expected 0 0", k, rsp_valid8, err_abort8); end
    end
    @(negedge clk); req_valid8 = 2'b01; #1;
    ntests++; if (req_ready8 !== 2'b01) begin
      nfail++; $display("FAIL r8_reaccept: req_ready=%b expected 01", req_ready8); end
    for (int k = 1; k <= NR8; k++) begin
      @(negedge clk); req_valid8 = 2'b00; #1;
      ntests++; if (rsp_valid8 !== 1'b0) begin
        nfail++; $display("FAIL r8_early%0d: rsp_valid=%b expected 0", k, rsp_valid8); end
    end
    @(negedge clk); #1;
    ntests++; if ({rsp_valid8, rsp_id8, rsp_ct8} !== {1'b1, 1'b0, CT_A8}) begin
      nfail++; $display("FAIL r8_response: valid=%b id=%b ct=%h expected 1 0 %h", rsp_valid8, rsp_id8, rsp_ct8, CT_A8); end
    @(negedge clk); rsp_ready = 1'b1; #1;
    @(negedge clk); rsp_ready = 1'b0; #1;
  endtask

  initial begin
    rst_n = 1'b0; key_ready = 1'b1; rsp_ready = 1'b0;
    req_valid4 = 2'b00; req_valid8 = 2'b00; req_pt = '0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    for (int r = 0; r < 16; r++) begin rk4[r] = '0; rk8[r] = '0; end
    expand({KEY128, 128'h0}, 4);
    for (int r = 0; r <= NR4; r++) rk4[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand(KEY256, 8);
    for (int r = 0; r <= NR8; r++) rk8[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    test_reset();
    test_single_block();
    test_backpressure();
    test_abort();
    test_arbitration();
    test_reset_mid_round();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
